// File: rtl/mem_stage_lsu_if.sv
// ============================================================================
// Module   : mem_stage_lsu_if
// Brief    : MEM-stage request/response and data-memory bus of the load/store unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_stage_lsu_if #(
    parameter int ADDR_BITS = 5
);
    logic                 req_valid;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [4:0]           req_rd;
    logic                 stall;
    logic                 load_valid;
    logic [31:0]          load_data;
    logic [4:0]           load_rd;
    logic                 err;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_wr;
    logic                 mem_rd_en;
    logic [31:0]          mem_rdata;

    // master is the LSU itself; slave is the pipeline plus data memory around it.
    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  mem_rdata,
        output stall, load_valid, load_data, load_rd, err,
        output mem_addr, mem_wdata, mem_wr, mem_rd_en
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
        output mem_rdata,
        input  stall, load_valid, load_data, load_rd, err,
        input  mem_addr, mem_wdata, mem_wr, mem_rd_en
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit; sub-word stores use a 2-cycle read-modify-write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int ADDR_BITS = 5
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mem_stage_lsu_if.master bus
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_t;

    state_t               state_q;
    logic                 load_valid_q;
    logic [31:0]          load_data_q;
    logic [4:0]           load_rd_q;
    logic                 err_q;
    logic [31:0]          merged_q;
    logic [ADDR_BITS-1:0] idx_q;

    logic                 w_idle;
    logic                 w_fault;
    logic                 w_load_go;
    logic                 w_word_st_go;
    logic                 w_sub_go;
    logic                 w_fault_go;
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          w_shifted;
    logic [31:0]          w_load_ext;
    logic [31:0]          merged_d;

    assign w_idx  = bus.req_addr[ADDR_BITS+1:2];
    assign w_idle = (state_q == S_IDLE) && !rst;

    always_comb begin
        w_fault = 1'b0;
        if (bus.req_size == 2'b11)
            w_fault = 1'b1;
        if (bus.req_size == 2'b01 && bus.req_addr[0])
            w_fault = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
            w_fault = 1'b1;
        if ((bus.req_addr >> (ADDR_BITS + 2)) != 32'd0)
            w_fault = 1'b1;
    end

    // In RMW_WR the upstream request is the one already being written; it is ignored.
    assign w_fault_go   = w_idle && bus.req_valid && w_fault;
    assign w_load_go    = w_idle && bus.req_valid && !w_fault && !bus.req_write;
    assign w_word_st_go = w_idle && bus.req_valid && !w_fault && bus.req_write
                          && (bus.req_size == 2'b10);
    assign w_sub_go     = w_idle && bus.req_valid && !w_fault && bus.req_write
                          && (bus.req_size != 2'b10);

    assign w_shifted = bus.mem_rdata >> {bus.req_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = bus.mem_rdata;
        case (bus.req_size)
            2'b00:   w_load_ext = {{24{bus.req_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_ext = {{16{bus.req_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merged_d = bus.mem_rdata;
        if (bus.req_size == 2'b00)
            merged_d[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
        else
            merged_d[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'd0;
            load_rd_q    <= 5'd0;
            err_q        <= 1'b0;
            merged_q     <= 32'd0;
            idx_q        <= '0;
        end else begin
            load_valid_q <= w_load_go;
            err_q        <= w_fault_go;
            if (w_load_go) begin
                load_data_q <= w_load_ext;
                load_rd_q   <= bus.req_rd;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_sub_go) begin
                        merged_q <= merged_d;
                        idx_q    <= w_idx;
                        state_q  <= S_RMW_WR;
                    end
                end
                S_RMW_WR: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stall      = w_sub_go;
    assign bus.mem_rd_en  = w_load_go || w_sub_go;
    assign bus.mem_wr     = w_word_st_go || ((state_q == S_RMW_WR) && !rst);
    assign bus.mem_addr   = (state_q == S_RMW_WR) ? idx_q : w_idx;
    assign bus.mem_wdata  = (state_q == S_RMW_WR) ? merged_q : bus.req_wdata;
    assign bus.load_valid = load_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.load_rd    = load_rd_q;
    assign bus.err        = err_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Scoreboard bench for mem_stage_lsu against a byte-array reference memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;
    localparam int AB = 5;
    localparam int NW = 1 << AB;
    localparam int NB = 4 * NW;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [4:0]  rd;
    } resp_t;

    typedef struct {
        logic [AB-1:0] idx;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_lsu_if #(.ADDR_BITS(AB)) bus ();
    mem_stage_lsu #(.ADDR_BITS(AB)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [NW];
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = bus.mem_rd_en ? mem[bus.mem_addr] : 32'd0;

    logic [7:0] rb [NB];
    resp_t rq[$];
    wr_t   wq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response and write monitor, sampling on the falling edge.
    initial begin
        resp_t e;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.load_valid || bus.err) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: load_valid=%0b err=%0b, none expected",
                                 bus.load_valid, bus.err);
                    end else begin
                        e = rq.pop_front();
                        chk("resp_err", {31'd0, bus.err}, {31'd0, e.is_err});
                        chk("resp_load_valid", {31'd0, bus.load_valid}, {31'd0, !e.is_err});
                        if (!e.is_err) begin
                            chk("load_data", bus.load_data, e.data);
                            chk("load_rd", {27'd0, bus.load_rd}, {27'd0, e.rd});
                        end
                    end
                end
                if (bus.mem_wr) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: idx=%0d data=%h, none expected",
                                 bus.mem_addr, bus.mem_wdata);
                    end else begin
                        w = wq.pop_front();
                        chk("write_idx", 32'(bus.mem_addr), 32'(w.idx));
                        chk("write_data", bus.mem_wdata, w.data);
                    end
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bit          fault;
        int          n;
        int          exp_stall;
        logic [31:0] v;
        int          base;
        resp_t       r;
        wr_t         w;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        fault = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
                (sz == 2'b10 && a % 4 != 0) || (a >= NB);
        exp_stall = 0;
        if (fault) begin
            r.is_err = 1'b1; r.data = 32'd0; r.rd = 5'd0;
            rq.push_back(r);
        end else if (!wr) begin
            if (sz == 2'b00) begin
                v = 32'(rb[a]);
                if (sg && v >= 128) v = v - 256;
            end else if (sz == 2'b01) begin
                v = 32'(rb[a]) + 256 * 32'(rb[a+1]);
                if (sg && v >= 32768) v = v - 65536;
            end else begin
                v = {rb[a+3], rb[a+2], rb[a+1], rb[a]};
            end
            r.is_err = 1'b0; r.data = v; r.rd = rd;
            rq.push_back(r);
        end else begin
            for (int i = 0; i < (1 << sz); i++) rb[a+i] = wd[8*i +: 8];
            base   = int'(a) & ~3;
            w.idx  = a[AB+1:2];
            w.data = {rb[base+3], rb[base+2], rb[base+1], rb[base]};
            wq.push_back(w);
            exp_stall = (sz == 2'b10) ? 0 : 1;
        end
        n = 0;
        @(negedge clk);
        while (bus.stall && n < 4) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(n), 32'(exp_stall));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_addr  = $urandom % NB;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
        for (int i = 0; i < NW; i++) begin
            mem[i] = $urandom;
            for (int k = 0; k < 4; k++) rb[4*i+k] = mem[i][8*k +: 8];
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, bus.stall, bus.load_valid, bus.err, bus.mem_wr,
                              bus.mem_rd_en, |bus.load_rd}, 32'd0);
        chk("reset_load_data", bus.load_data, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            @(negedge clk);
            chk("idle_quiet", {27'd0, bus.stall, bus.load_valid, bus.err, bus.mem_wr,
                               bus.mem_rd_en}, 32'd0);
        end

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 5'd7);
        issue(1, 2'b00, 0, 32'h11, 32'h5A, 5'd0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 5'd3);
        issue(0, 2'b00, 1, 32'h13, 32'h0, 5'd1);
        issue(0, 2'b00, 0, 32'h13, 32'h0, 5'd2);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 5'd4);
        issue(0, 2'b01, 0, 32'h10, 32'h0, 5'd5);
        issue(0, 2'b10, 0, 32'h12, 32'h0, 5'd6);
        issue(1, 2'b01, 0, 32'h11, 32'hFFFF, 5'd0);
        issue(1, 2'b10, 0, 32'h80, 32'h12345678, 5'd0);
        issue(0, 2'b11, 0, 32'h0, 32'h0, 5'd8);

        // Reset while the RMW write is pending: the write must not happen.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
        bus.req_addr = 32'h12; bus.req_wdata = 32'h1234;
        @(negedge clk);
        chk("rmw_first_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_rmw_no_write", {31'd0, bus.mem_wr}, 32'd0);
        #1 rst = 1'b0;
        issue(0, 2'b10, 0, 32'h10, 32'h0, 5'd9);

        for (int it = 0; it < 400; it++) begin
            if ($urandom % 6 == 0) begin
                idle_cycle();
            end else begin
                sz = 2'($urandom % 8 == 0 ? 3 : $urandom % 3);
                a  = ($urandom % 16 == 0) ? $urandom : ($urandom % NB);
                if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 1);
                if ($urandom % 10 == 0) a = a & 32'h1F;
                issue(1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom));
            end
        end

        repeat (4) idle_cycle();
        @(negedge clk);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
